// File: rtl/multicycle_controller_if.sv
// Control bundle between the piRISC multicycle controller and its datapath/memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_controller_if #(
  parameter int OPWIDTH = 7
) ();
  logic [OPWIDTH-1:0] opcode;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               iord;
  logic               ir_write;
  logic               pc_write;
  logic               mdr_write;
  logic               aluout_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               alu_force_add;
  logic               reg_write;
  logic               wb_sel;
  logic               fault;
  logic [3:0]         state;

  // Memory handshake: mem_req rises with the request and stays high until the
  // cycle in which mem_ready=1 completes it; mem_we/iord are valid while mem_req=1.
  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, mdr_write, aluout_write,
           alu_src_a, alu_src_b, alu_force_add, reg_write, wb_sel, fault, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, mdr_write, aluout_write,
           alu_src_a, alu_src_b, alu_force_add, reg_write, wb_sel, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the piRISC multicycle core: fetch/decode/execute/memory/writeback
// sequencing with a supervised memory handshake that falls into a sticky FAULT state.
module multicycle_controller #(
  parameter int OPWIDTH = 7,
  parameter int TWIDTH  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    START   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC    = 4'd3,
    MEMADDR = 4'd4,
    MEMRD   = 4'd5,
    MEMWR   = 4'd6,
    WB      = 4'd7,
    FAULT   = 4'd8
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       fetch_en;
    logic       mdr_en;
    logic       aluout_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_force_add;
    logic       reg_write;
    logic       wb_sel;
    logic       fault;
  } ctrl_t;

  localparam logic [OPWIDTH-1:0] OP_R     = OPWIDTH'(7'b0110011);
  localparam logic [OPWIDTH-1:0] OP_I     = OPWIDTH'(7'b0010011);
  localparam logic [OPWIDTH-1:0] OP_LOAD  = OPWIDTH'(7'b0000011);
  localparam logic [OPWIDTH-1:0] OP_STORE = OPWIDTH'(7'b0100011);
  localparam logic [TWIDTH-1:0]  TMO_LIM  = TWIDTH'(TIMEOUT);
  localparam logic [TWIDTH-1:0]  TMO_MAX  = {TWIDTH{1'b1}};

  state_t              state_q, state_d;
  ctrl_t               ctrl_q;
  logic [TWIDTH-1:0]   tmo_q, tmo_d;
  logic                wait_cyc;

  // Moore part of the control word for a given state; the opcode it reads is
  // already stable when the state is entered.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OPWIDTH-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req       = 1'b1;
        c.fetch_en      = 1'b1;
        c.alu_src_b     = 2'b01;
        c.alu_force_add = 1'b1;
      end
      EXEC: begin
        c.alu_src_a    = 1'b1;
        c.aluout_write = 1'b1;
        c.alu_src_b    = (op == OP_I) ? 2'b10 : 2'b00;
      end
      MEMADDR: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b10;
        c.alu_force_add = 1'b1;
        c.aluout_write  = 1'b1;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mdr_en  = 1'b1;
      end
      MEMWR: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = 1'b1;
      end
      WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = (op == OP_LOAD);
      end
      FAULT:   c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_cyc = ctrl_q.mem_req & ~bus.mem_ready;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      START:   state_d = FETCH;
      FETCH:   if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        if (bus.opcode == OP_R || bus.opcode == OP_I)              state_d = EXEC;
        else if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE)  state_d = MEMADDR;
        else                                                       state_d = FAULT;
      end
      EXEC:    state_d = WB;
      MEMADDR: state_d = (bus.opcode == OP_LOAD) ? MEMRD : MEMWR;
      MEMRD:   if (bus.mem_ready) state_d = WB;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      WB:      state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    // A ready in the limit cycle still completes the request normally.
    if (wait_cyc && tmo_q == TMO_LIM) state_d = FAULT;

    if (!wait_cyc)            tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TWIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      tmo_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      ctrl_q  <= decode_ctrl(state_d, bus.opcode);
    end
  end

  assign bus.mem_req       = ctrl_q.mem_req;
  assign bus.mem_we        = ctrl_q.mem_we;
  assign bus.iord          = ctrl_q.iord;
  assign bus.ir_write      = ctrl_q.fetch_en & bus.mem_ready;
  assign bus.pc_write      = ctrl_q.fetch_en & bus.mem_ready;
  assign bus.mdr_write     = ctrl_q.mdr_en & bus.mem_ready;
  assign bus.aluout_write  = ctrl_q.aluout_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_force_add = ctrl_q.alu_force_add;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.wb_sel        = ctrl_q.wb_sel;
  assign bus.fault         = ctrl_q.fault;
  assign bus.state         = state_q;

endmodule
